// File: rtl/cache_controller_pkg.sv
// Shared geometry helpers and FSM state encoding for the cache controller and its tag shadow.
package cache_controller_pkg;

  localparam int DEF_ADDR_WIDTH = 28;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BLOCK_SIZE = 256;
  localparam int DEF_CACHE_SIZE = 65536;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    REFILL    = 3'd3,
    UPDATE    = 3'd4
  } state_t;

  function automatic int clog2_int(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/cache_tag_shadow.sv
// Tag/valid copy of the cache array used to address dirty victims.
// One-cycle synchronous read; valid vector cleared by reset, tag RAM left uninitialised.
module cache_tag_shadow
  import cache_controller_pkg::*;
#(
  parameter int INDEX_WIDTH = 11,
  parameter int TAG_WIDTH   = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic                   rd_valid,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [TAG_WIDTH-1:0]   wr_tag
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  logic [TAG_WIDTH-1:0] tag_mem [DEPTH];
  logic [DEPTH-1:0]     valid;

  always_ff @(posedge clk) begin
    if (wr_en) tag_mem[wr_index] <= wr_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= '0;
      rd_valid <= 1'b0;
      rd_tag   <= '0;
    end else begin
      if (wr_en) valid[wr_index] <= 1'b1;
      if (rd_en) begin
        rd_valid <= valid[rd_index];
        rd_tag   <= tag_mem[rd_index];
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-back cache sequencer: lookup, dirty write-back, refill, array update.
// Outputs are decoded from state and registers; mem_ack never reaches cpu_ready combinationally.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int CACHE_SIZE = DEF_CACHE_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-clog2_int(BLOCK_SIZE/DATA_WIDTH)-1:0] mem_addr,
  output logic [BLOCK_SIZE-1:0] mem_wdata,
  input  logic [BLOCK_SIZE-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [BLOCK_SIZE-1:0] c_data_write,
  output logic                  c_dirty_write,
  output logic                  c_write_en,
  input  logic [BLOCK_SIZE-1:0] c_data_read,
  input  logic                  c_dirty_read,
  input  logic                  c_hit
);

  localparam int NUM_BLOCKS   = CACHE_SIZE / (BLOCK_SIZE / 8);
  localparam int OFFSET_WIDTH = clog2_int(BLOCK_SIZE / DATA_WIDTH);
  localparam int INDEX_WIDTH  = clog2_int(NUM_BLOCKS);
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_we;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [BLOCK_SIZE-1:0]   victim;
  logic [BLOCK_SIZE-1:0]   line;
  logic [BLOCK_SIZE-1:0]   merged;
  logic [TAG_WIDTH-1:0]    shadow_tag;
  logic                    shadow_valid;
  logic                    shadow_we;
  logic [OFFSET_WIDTH-1:0] req_off;
  logic [INDEX_WIDTH-1:0]  req_idx;
  logic [TAG_WIDTH-1:0]    req_tag;

  assign req_off = req_addr[OFFSET_WIDTH-1:0];
  assign req_idx = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_tag = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign c_addr  = (state == IDLE) ? cpu_addr : req_addr;

  always_comb begin
    merged = line;
    if (req_we) merged[req_off*DATA_WIDTH +: DATA_WIDTH] = req_wdata;
  end

  // The array has no tag read port, so victim addresses come from this copy.
  cache_tag_shadow #(
    .INDEX_WIDTH(INDEX_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (state == IDLE),
    .rd_index(cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH]),
    .rd_tag  (shadow_tag),
    .rd_valid(shadow_valid),
    .wr_en   (shadow_we),
    .wr_index(req_idx),
    .wr_tag  (req_tag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      victim    <= '0;
      line      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_addr  <= cpu_addr;
            req_we    <= cpu_we;
            req_wdata <= cpu_wdata;
          end
        end
        LOOKUP: begin
          if (c_hit) line <= c_data_read;
          else if (shadow_valid && c_dirty_read) victim <= c_data_read;
        end
        REFILL: begin
          if (mem_ack) line <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    cpu_ready     = 1'b0;
    cpu_rdata     = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    c_write_en    = 1'b0;
    c_dirty_write = 1'b0;
    c_data_write  = '0;
    shadow_we     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (c_hit) begin
          if (req_we) begin
            state_nxt = UPDATE;
          end else begin
            cpu_ready = 1'b1;
            cpu_rdata = c_data_read[req_off*DATA_WIDTH +: DATA_WIDTH];
            state_nxt = IDLE;
          end
        end else if (shadow_valid && c_dirty_read) begin
          state_nxt = WRITEBACK;
        end else begin
          state_nxt = REFILL;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {shadow_tag, req_idx};
        mem_wdata = victim;
        if (mem_ack) state_nxt = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx};
        if (mem_ack) state_nxt = UPDATE;
      end
      UPDATE: begin
        // A write hit always carries req_we=1, so the dirty bit is just the request type.
        c_write_en    = 1'b1;
        c_data_write  = merged;
        c_dirty_write = req_we;
        shadow_we     = 1'b1;
        cpu_ready     = 1'b1;
        cpu_rdata     = merged[req_off*DATA_WIDTH +: DATA_WIDTH];
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller with behavioural models of the cache array and main memory.
module tb_cache_controller;
  localparam int BW = 256;
  localparam int NB = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [27:0]   cpu_addr;
  logic [31:0]   cpu_wdata, cpu_rdata;
  logic          cpu_ready;
  logic          mem_req, mem_we;
  logic [24:0]   mem_addr;
  logic [BW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic [27:0]   c_addr;
  logic [BW-1:0] c_data_write, c_data_read;
  logic          c_dirty_write, c_write_en, c_dirty_read, c_hit;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .c_addr(c_addr), .c_data_write(c_data_write), .c_dirty_write(c_dirty_write),
    .c_write_en(c_write_en), .c_data_read(c_data_read), .c_dirty_read(c_dirty_read),
    .c_hit(c_hit)
  );

  // Behavioural cache array: write then read at the falling edge.
  logic [BW-1:0] arr_data  [NB];
  logic [13:0]   arr_tag   [NB];
  logic          arr_valid [NB];
  logic          arr_dirty [NB];

  initial begin
    for (int k = 0; k < NB; k++) begin
      arr_data[k] = '0; arr_tag[k] = '0; arr_valid[k] = 1'b0; arr_dirty[k] = 1'b0;
    end
    c_hit = 1'b0; c_data_read = '0; c_dirty_read = 1'b0;
  end

  always @(negedge clk) begin
    int i;
    if (rst) begin
      for (int k = 0; k < NB; k++) begin arr_valid[k] = 1'b0; arr_dirty[k] = 1'b0; end
    end else if (c_write_en) begin
      i = int'(c_addr[13:3]);
      arr_data[i] = c_data_write; arr_tag[i] = c_addr[27:14];
      arr_valid[i] = 1'b1; arr_dirty[i] = c_dirty_write;
    end
    i = int'(c_addr[13:3]);
    c_hit        = arr_valid[i] && (arr_tag[i] == c_addr[27:14]);
    c_data_read  = arr_data[i];
    c_dirty_read = arr_valid[i] && arr_dirty[i];
  end

  // Main memory and flat word-level reference memory
  logic [BW-1:0] mm   [logic [24:0]];
  logic [31:0]   gold [logic [27:0]];

  function automatic logic [BW-1:0] mm_rd(input logic [24:0] b);
    logic [BW-1:0] v;
    logic [2:0] k3;
    if (mm.exists(b)) return mm[b];
    for (int k = 0; k < 8; k++) begin
      k3 = 3'(k);
      v[k*32 +: 32] = {b, k3, 4'h5};
    end
    return v;
  endfunction

  function automatic logic [31:0] gold_rd(input logic [27:0] a);
    logic [BW-1:0] blk;
    if (gold.exists(a)) return gold[a];
    blk = mm_rd(a[27:3]);
    return blk[a[2:0]*32 +: 32];
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          nwb;
    int          nrf;
    logic [24:0] wb_addr;
    logic [BW-1:0] wb_data;
    logic [24:0] rf_addr;
    logic        upd_seen;
    logic        upd_dirty;
    logic        timeout;
  } obs_t;

  // One CPU transaction; memory acks on the (dly+1)-th cycle of each mem_req.
  task automatic run_txn(input logic we, input logic [27:0] a, input logic [31:0] wd,
                         input int dly, output obs_t o);
    int wait_cnt;
    o.rdata = '0; o.lat = 0; o.nwb = 0; o.nrf = 0; o.wb_addr = '0; o.wb_data = '0;
    o.rf_addr = '0; o.upd_seen = 1'b0; o.upd_dirty = 1'b0; o.timeout = 1'b1;
    step();
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    wait_cnt = 0;
    for (int c = 1; c <= 400; c++) begin
      step();
      mem_ack = 1'b0;
      if (c_write_en) begin o.upd_seen = 1'b1; o.upd_dirty = c_dirty_write; end
      if (cpu_ready) begin
        o.rdata = cpu_rdata; o.lat = c; o.timeout = 1'b0;
        break;
      end
      if (mem_req) begin
        wait_cnt++;
        if (wait_cnt > dly) begin
          if (mem_we) begin
            o.nwb++; o.wb_addr = mem_addr; o.wb_data = mem_wdata; mm[mem_addr] = mem_wdata;
          end else begin
            o.nrf++; o.rf_addr = mem_addr; mem_rdata = mm_rd(mem_addr);
          end
          mem_ack = 1'b1;
          wait_cnt = 0;
        end
      end
    end
    cpu_req = 1'b0;
    chk("txn_completes", {255'd0, o.timeout}, '0);
  endtask

  typedef struct {
    logic        we;
    logic [27:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_nwb;
    int          exp_nrf;
    logic [24:0] exp_wb_addr;
    int          wb_off;
    logic [31:0] exp_wb_word;
    logic [24:0] exp_rf_addr;
    logic        exp_upd;
    logic        exp_dirty;
  } vec_t;

  vec_t tv [8];

  initial begin
    obs_t o;
    int   quiet, late;
    bit   seen;
    logic [31:0] ww;
    logic [BW-1:0] blk;
    logic        dv [4];
    logic [13:0] dt [4];
    logic        dd [4];

    //          we    addr        wdata         dly rdata         lat wb rf wb_addr   off wb_word       rf_addr   upd   dirty
    tv[0] = '{1'b0, 28'h0000010, 32'h0,        3,  32'h11111111, 6,  0, 1, 25'h0,    0,  32'h0,        25'h002,  1'b1, 1'b0};
    tv[1] = '{1'b0, 28'h0000012, 32'h0,        0,  32'h33333333, 1,  0, 0, 25'h0,    0,  32'h0,        25'h0,    1'b0, 1'b0};
    tv[2] = '{1'b1, 28'h0000011, 32'hDEADBEEF, 0,  32'hDEADBEEF, 2,  0, 0, 25'h0,    0,  32'h0,        25'h0,    1'b1, 1'b1};
    tv[3] = '{1'b0, 28'h0000011, 32'h0,        0,  32'hDEADBEEF, 1,  0, 0, 25'h0,    0,  32'h0,        25'h0,    1'b0, 1'b0};
    tv[4] = '{1'b0, 28'h0004010, 32'h0,        0,  32'hA0000000, 4,  1, 1, 25'h002,  1,  32'hDEADBEEF, 25'h802,  1'b1, 1'b0};
    tv[5] = '{1'b1, 28'h0004011, 32'h12345678, 0,  32'h12345678, 2,  0, 0, 25'h0,    0,  32'h0,        25'h0,    1'b1, 1'b1};
    tv[6] = '{1'b1, 28'h0000017, 32'hCAFEF00D, 20, 32'hCAFEF00D, 44, 1, 1, 25'h802,  1,  32'h12345678, 25'h002,  1'b1, 1'b1};
    tv[7] = '{1'b0, 28'h0000011, 32'h0,        0,  32'hDEADBEEF, 1,  0, 0, 25'h0,    0,  32'h0,        25'h0,    1'b0, 1'b0};

    for (int k = 0; k < 8; k++) begin
      blk[k*32 +: 32] = 32'h11111111 * (k + 1);
    end
    mm[25'h002] = blk;
    for (int k = 0; k < 8; k++) begin
      blk[k*32 +: 32] = 32'hA0000000 + k;
    end
    mm[25'h802] = blk;

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    chk("rst_cpu_ready", {255'd0, cpu_ready}, '0);
    chk("rst_cpu_rdata", {224'd0, cpu_rdata}, '0);
    chk("rst_mem_req", {255'd0, mem_req}, '0);
    chk("rst_mem_we", {255'd0, mem_we}, '0);
    chk("rst_mem_addr", {231'd0, mem_addr}, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_c_write_en", {255'd0, c_write_en}, '0);
    chk("rst_c_dirty_write", {255'd0, c_dirty_write}, '0);
    chk("rst_c_data_write", c_data_write, '0);
    rst = 1'b0;

    for (int r = 0; r < 8; r++) begin
      run_txn(tv[r].we, tv[r].addr, tv[r].wdata, tv[r].dly, o);
      chk($sformatf("v%0d_rdata", r), {224'd0, o.rdata}, {224'd0, tv[r].exp_rdata});
      chk($sformatf("v%0d_latency", r), BW'(o.lat), BW'(tv[r].exp_lat));
      chk($sformatf("v%0d_writebacks", r), BW'(o.nwb), BW'(tv[r].exp_nwb));
      chk($sformatf("v%0d_refills", r), BW'(o.nrf), BW'(tv[r].exp_nrf));
      chk($sformatf("v%0d_update_seen", r), {255'd0, o.upd_seen}, {255'd0, tv[r].exp_upd});
      if (tv[r].exp_upd)
        chk($sformatf("v%0d_dirty_write", r), {255'd0, o.upd_dirty}, {255'd0, tv[r].exp_dirty});
      if (tv[r].exp_nwb > 0) begin
        chk($sformatf("v%0d_wb_addr", r), {231'd0, o.wb_addr}, {231'd0, tv[r].exp_wb_addr});
        ww = o.wb_data[tv[r].wb_off*32 +: 32];
        chk($sformatf("v%0d_wb_word", r), {224'd0, ww}, {224'd0, tv[r].exp_wb_word});
      end
      if (tv[r].exp_nrf > 0)
        chk($sformatf("v%0d_rf_addr", r), {231'd0, o.rf_addr}, {231'd0, tv[r].exp_rf_addr});
      quiet = 0;
      for (int c = 0; c < 3; c++) begin
        step();
        if (cpu_ready || mem_req) quiet++;
      end
      chk($sformatf("v%0d_quiet_after", r), BW'(quiet), '0);
    end

    // Reset while waiting for a refill ack, then a late ack.
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 28'h0008020;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (mem_req) seen = 1'b1;
    end
    chk("rstmid_refill_reached", {255'd0, seen}, {255'd0, 1'b1});
    chk("rstmid_refill_we", {255'd0, mem_we}, '0);
    chk("rstmid_refill_addr", {231'd0, mem_addr}, {231'd0, 25'h1004});
    rst = 1'b1; cpu_req = 1'b0;
    step();
    chk("rstmid_mem_req_drop", {255'd0, mem_req}, '0);
    chk("rstmid_no_ready", {255'd0, cpu_ready}, '0);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = '1;
    step();
    mem_ack = 1'b0;
    late = 0;
    for (int c = 0; c < 4; c++) begin
      if (cpu_ready || mem_req) late++;
      step();
    end
    chk("rstmid_late_ack_ignored", BW'(late), '0);
    run_txn(1'b0, 28'h0000010, 32'h0, 1, o);
    chk("rstmid_fresh_rdata", {224'd0, o.rdata}, {224'd0, 32'h11111111});
    chk("rstmid_fresh_refills", BW'(o.nrf), BW'(1));
    chk("rstmid_fresh_writebacks", BW'(o.nwb), '0);
    chk("rstmid_fresh_rf_addr", {231'd0, o.rf_addr}, {231'd0, 25'h002});
    chk("rstmid_fresh_latency", BW'(o.lat), BW'(4));

    // Randomised traffic against a direct-mapped write-back directory model.
    rst = 1'b1; step(); step(); rst = 1'b0;
    gold.delete();
    for (int k = 0; k < 4; k++) begin dv[k] = 1'b0; dt[k] = '0; dd[k] = 1'b0; end
    for (int t = 0; t < 150; t++) begin
      logic        we, hit, e_wb;
      logic [13:0] tg;
      logic [10:0] ix;
      logic [2:0]  off;
      logic [27:0] a;
      logic [31:0] wd, e_rd;
      int          dly, e_lat;
      we  = 1'($urandom_range(0, 1));
      tg  = 14'($urandom_range(0, 3));
      ix  = 11'($urandom_range(0, 3));
      off = 3'($urandom_range(0, 7));
      a   = {tg, ix, off};
      wd  = $urandom;
      dly = int'($urandom_range(0, 3));
      hit  = dv[ix[1:0]] && (dt[ix[1:0]] == tg);
      e_wb = !hit && dv[ix[1:0]] && dd[ix[1:0]];
      if (hit) e_lat = we ? 2 : 1;
      else     e_lat = e_wb ? 4 + 2 * dly : 3 + dly;
      e_rd = we ? wd : gold_rd(a);
      run_txn(we, a, wd, dly, o);
      chk($sformatf("rnd%0d_rdata", t), {224'd0, o.rdata}, {224'd0, e_rd});
      chk($sformatf("rnd%0d_latency", t), BW'(o.lat), BW'(e_lat));
      chk($sformatf("rnd%0d_writebacks", t), BW'(o.nwb), BW'(e_wb ? 1 : 0));
      chk($sformatf("rnd%0d_refills", t), BW'(o.nrf), BW'(hit ? 0 : 1));
      if (e_wb)
        chk($sformatf("rnd%0d_wb_addr", t), {231'd0, o.wb_addr}, {231'd0, dt[ix[1:0]], ix});
      if (we) gold[a] = wd;
      if (!hit) begin
        dv[ix[1:0]] = 1'b1; dt[ix[1:0]] = tg; dd[ix[1:0]] = we;
      end else if (we) begin
        dd[ix[1:0]] = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
